// File: rtl/vga_timing_pkg.sv
// Default VGA 640x480@60 timing constants, derived window bounds and the
// 10-bit count type shared by the timing generator.
package vga_timing_pkg;

  typedef logic [9:0] count_t;

  localparam int CLK_DIV    = 4;
  localparam int H_SYNC     = 96;
  localparam int H_BP       = 48;
  localparam int H_VIS      = 640;
  localparam int H_FP       = 16;
  localparam int V_SYNC     = 2;
  localparam int V_BP       = 33;
  localparam int V_VIS      = 480;
  localparam int V_FP       = 10;
  localparam int SYNC_DELAY = 2;

  localparam int H_TOTAL     = H_SYNC + H_BP + H_VIS + H_FP;
  localparam int V_TOTAL     = V_SYNC + V_BP + V_VIS + V_FP;
  localparam int H_VIS_START = H_SYNC + H_BP;
  localparam int H_VIS_END   = H_VIS_START + H_VIS;
  localparam int V_VIS_START = V_SYNC + V_BP;
  localparam int V_VIS_END   = V_VIS_START + V_VIS;

  // Half-open window test: lo <= c < hi, all 10-bit unsigned.
  function automatic logic in_window(count_t c, count_t lo, count_t hi);
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_clk_en_divider.sv
// Registered clock-enable generator: en is high for the one clk in which
// the internal divider sits at DIV-1; DIV = 1 gives a continuous enable.
module clk_en_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic en
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_q, div_d;
  logic          en_q, en_d;

  always_comb begin
    div_d = (div_q == LAST) ? '0 : div_q + 1'b1;
    en_d  = (div_d == LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      en_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      en_q  <= en_d;
    end
  end

  assign en = en_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing generator: pixel/line counters, syncs, bright window and frame
// tick/count. Define VGA_SYNC_DELAY_EN to delay hSync/vSync by SYNC_DELAY clk.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = vga_timing_pkg::CLK_DIV,
  parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
  parameter int H_BP    = vga_timing_pkg::H_BP,
  parameter int H_VIS   = vga_timing_pkg::H_VIS,
  parameter int H_FP    = vga_timing_pkg::H_FP,
  parameter int V_SYNC  = vga_timing_pkg::V_SYNC,
  parameter int V_BP    = vga_timing_pkg::V_BP,
  parameter int V_VIS   = vga_timing_pkg::V_VIS,
  parameter int V_FP    = vga_timing_pkg::V_FP
`ifdef VGA_SYNC_DELAY_EN
  ,
  parameter int SYNC_DELAY = vga_timing_pkg::SYNC_DELAY
`endif
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       bright,
  output logic       hSync,
  output logic       vSync,
  output logic       pix_en,
  output logic       frame_tick,
  output logic [7:0] frame_count
);

  localparam count_t H_WRAP     = count_t'(H_SYNC + H_BP + H_VIS + H_FP - 1);
  localparam count_t V_WRAP     = count_t'(V_SYNC + V_BP + V_VIS + V_FP - 1);
  localparam count_t H_SYNC_END = count_t'(H_SYNC);
  localparam count_t V_SYNC_END = count_t'(V_SYNC);
  localparam count_t H_ON       = count_t'(H_SYNC + H_BP);
  localparam count_t H_OFF      = count_t'(H_SYNC + H_BP + H_VIS);
  localparam count_t V_ON       = count_t'(V_SYNC + V_BP);
  localparam count_t V_OFF      = count_t'(V_SYNC + V_BP + V_VIS);

  logic       pix_en_w;
  count_t     h_q, h_d, v_q, v_d;
  logic [7:0] fc_q, fc_d;
  logic       tick_q, tick_d;
  logic       hs_q, hs_d, vs_q, vs_d;
  logic       bright_q, bright_d;

  clk_en_divider #(.DIV(CLK_DIV)) u_pix_div (
    .clk   (clk),
    .reset (reset),
    .en    (pix_en_w)
  );

  // Syncs and bright are derived from the next counts so they switch in the
  // same clk as the counters they describe.
  always_comb begin
    h_d    = h_q;
    v_d    = v_q;
    fc_d   = fc_q;
    tick_d = 1'b0;
    if (pix_en_w) begin
      if (h_q == H_WRAP) begin
        h_d = '0;
        if (v_q == V_WRAP) begin
          v_d    = '0;
          tick_d = 1'b1;
          fc_d   = fc_q + 8'd1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    hs_d     = (h_d >= H_SYNC_END);
    vs_d     = (v_d >= V_SYNC_END);
    bright_d = in_window(h_d, H_ON, H_OFF) && in_window(v_d, V_ON, V_OFF);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q      <= '0;
      v_q      <= '0;
      fc_q     <= '0;
      tick_q   <= 1'b0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      bright_q <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      fc_q     <= fc_d;
      tick_q   <= tick_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      bright_q <= bright_d;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  // Delay line lines the syncs up with the ROM read + registered rgb path.
  logic [SYNC_DELAY-1:0] hs_dly_q, hs_dly_d, vs_dly_q, vs_dly_d;

  always_comb begin
    hs_dly_d    = hs_dly_q;
    vs_dly_d    = vs_dly_q;
    hs_dly_d[0] = hs_q;
    vs_dly_d[0] = vs_q;
    for (int i = 1; i < SYNC_DELAY; i++) begin
      hs_dly_d[i] = hs_dly_q[i-1];
      vs_dly_d[i] = vs_dly_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_dly_q <= '0;
      vs_dly_q <= '0;
    end else begin
      hs_dly_q <= hs_dly_d;
      vs_dly_q <= vs_dly_d;
    end
  end

  assign hSync = hs_dly_q[SYNC_DELAY-1];
  assign vSync = vs_dly_q[SYNC_DELAY-1];
`else
  assign hSync = hs_q;
  assign vSync = vs_q;
`endif

  assign hCount      = h_q;
  assign vCount      = v_q;
  assign bright      = bright_q;
  assign pix_en      = pix_en_w;
  assign frame_tick  = tick_q;
  assign frame_count = fc_q;

endmodule
